// File: rtl/vms_pkg.sv
// Shared types and constants for the vector memory sequencer.
// Optional stride support is controlled by the VMS_STRIDE_EN macro in the top module.
package vms_pkg;

    localparam int LANES   = 16;
    localparam int LANE_W  = 16;
    localparam int VEC_W   = LANES * LANE_W;
    localparam int ADDR_W  = 16;
    localparam int REG_AW  = 3;
    localparam int LANE_IW = $clog2(LANES);

    typedef logic [LANE_IW-1:0] lane_t;

    localparam lane_t LAST_LANE = lane_t'(LANES - 1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_WAIT = 3'd1,
        ST_STORE   = 3'd2,
        ST_LOAD    = 3'd3,
        ST_WRBACK  = 3'd4,
        ST_DONE    = 3'd5
    } state_e;

endpackage

// File: rtl/vms_if.sv
// Word-wide data-memory port: the sequencer is master, the memory is slave.
interface vms_mem_if;
    import vms_pkg::*;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [LANE_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [LANE_W-1:0] mem_rdata;

    modport master (output mem_req, mem_we, mem_addr, mem_wdata,
                    input  mem_ack, mem_rdata);
    modport slave  (input  mem_req, mem_we, mem_addr, mem_wdata,
                    output mem_ack, mem_rdata);
endinterface

// File: rtl/vms_lane_buffer.sv
// 256-bit lane buffer: whole-vector load, single-lane write, single-lane read mux.
module vms_lane_buffer
    import vms_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_en,
    input  logic [VEC_W-1:0]  load_data,
    input  logic              wr_en,
    input  lane_t             wr_idx,
    input  logic [LANE_W-1:0] wr_data,
    input  lane_t             rd_idx,
    output logic [LANE_W-1:0] rd_data,
    output logic [VEC_W-1:0]  vec
);

    logic [VEC_W-1:0] vec_q;
    logic [VEC_W-1:0] vec_d;

    // Next buffer contents: full load wins over a lane write.
    always_comb begin
        vec_d = vec_q;
        if (load_en) begin
            vec_d = load_data;
        end else if (wr_en) begin
            vec_d[wr_idx*LANE_W +: LANE_W] = wr_data;
        end else begin
            vec_d = vec_q;
        end
    end

    // Buffer storage; reset clears any partially gathered vector.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec_q <= {VEC_W{1'b0}};
        end else begin
            vec_q <= vec_d;
        end
    end

    assign rd_data = vec_q[rd_idx*LANE_W +: LANE_W];
    assign vec     = vec_q;

endmodule

// File: rtl/vector_mem_sequencer.sv
// Moves one vector register to/from data memory, one 16-bit lane per beat.
// Define VMS_STRIDE_EN to add a per-command `stride` input; otherwise unit stride.
module vector_mem_sequencer
    import vms_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              op_load,
    input  logic [REG_AW-1:0] vreg,
    input  logic [ADDR_W-1:0] base_addr,
`ifdef VMS_STRIDE_EN
    input  logic [ADDR_W-1:0] stride,
`endif
    output logic              busy,
    output logic              done,
    output logic [REG_AW-1:0] rf_rd_addr,
    input  logic [VEC_W-1:0]  rf_rd_data,
    output logic [REG_AW-1:0] rf_wr_dst,
    output logic [VEC_W-1:0]  rf_wr_data,
    output logic              rf_wr_en,
    vms_mem_if.master         mem
);

    state_e            state_q, state_d;
    lane_t             lane_q, lane_d;
    logic [REG_AW-1:0] vreg_q, vreg_d;
    logic [ADDR_W-1:0] stride_q, stride_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              rf_wr_en_q, rf_wr_en_d;
    logic [REG_AW-1:0] rf_wr_dst_q, rf_wr_dst_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [LANE_W-1:0] mem_wdata_q, mem_wdata_d;

    logic              lbuf_load_s;
    logic              lbuf_wr_s;
    lane_t             lbuf_rd_idx_s;
    logic [LANE_W-1:0] lbuf_rd_s;
    logic [VEC_W-1:0]  lbuf_vec_s;
    logic              beat_ack_s;
    logic [ADDR_W-1:0] stride_in_s;

`ifdef VMS_STRIDE_EN
    assign stride_in_s = stride;
`else
    assign stride_in_s = {{(ADDR_W-1){1'b0}}, 1'b1};
`endif

    assign beat_ack_s    = mem.mem_ack & mem_req_q;
    assign lbuf_rd_idx_s = lane_q + lane_t'(1);

    vms_lane_buffer u_lane_buffer (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_en   (lbuf_load_s),
        .load_data (rf_rd_data),
        .wr_en     (lbuf_wr_s),
        .wr_idx    (lane_q),
        .wr_data   (mem.mem_rdata),
        .rd_idx    (lbuf_rd_idx_s),
        .rd_data   (lbuf_rd_s),
        .vec       (lbuf_vec_s)
    );

    // Next-state and next-output logic; beat addresses advance by stride so no multiplier is needed.
    always_comb begin
        state_d     = state_q;
        lane_d      = lane_q;
        vreg_d      = vreg_q;
        stride_d    = stride_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        rf_wr_en_d  = 1'b0;
        rf_wr_dst_d = {REG_AW{1'b0}};
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        lbuf_load_s = 1'b0;
        lbuf_wr_s   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    vreg_d     = vreg;
                    stride_d   = stride_in_s;
                    mem_addr_d = base_addr;
                    lane_d     = lane_t'(0);
                    busy_d     = 1'b1;
                    if (op_load) begin
                        state_d   = ST_LOAD;
                        mem_req_d = 1'b1;
                        mem_we_d  = 1'b0;
                    end else begin
                        state_d   = ST_RD_WAIT;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RD_WAIT: begin
                lbuf_load_s = 1'b1;
                mem_req_d   = 1'b1;
                mem_we_d    = 1'b1;
                mem_wdata_d = rf_rd_data[LANE_W-1:0];
                state_d     = ST_STORE;
            end
            ST_STORE: begin
                if (beat_ack_s) begin
                    if (lane_q == LAST_LANE) begin
                        state_d     = ST_DONE;
                        lane_d      = lane_t'(0);
                        mem_req_d   = 1'b0;
                        mem_we_d    = 1'b0;
                        mem_addr_d  = {ADDR_W{1'b0}};
                        mem_wdata_d = {LANE_W{1'b0}};
                        busy_d      = 1'b0;
                        done_d      = 1'b1;
                    end else begin
                        lane_d      = lane_q + lane_t'(1);
                        mem_addr_d  = mem_addr_q + stride_q;
                        mem_wdata_d = lbuf_rd_s;
                    end
                end else begin
                    state_d = ST_STORE;
                end
            end
            ST_LOAD: begin
                if (beat_ack_s) begin
                    lbuf_wr_s = 1'b1;
                    if (lane_q == LAST_LANE) begin
                        state_d     = ST_WRBACK;
                        lane_d      = lane_t'(0);
                        mem_req_d   = 1'b0;
                        mem_addr_d  = {ADDR_W{1'b0}};
                        rf_wr_en_d  = 1'b1;
                        rf_wr_dst_d = vreg_q;
                    end else begin
                        lane_d     = lane_q + lane_t'(1);
                        mem_addr_d = mem_addr_q + stride_q;
                    end
                end else begin
                    state_d = ST_LOAD;
                end
            end
            ST_WRBACK: begin
                state_d = ST_DONE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d   = ST_IDLE;
                busy_d    = 1'b0;
                mem_req_d = 1'b0;
                mem_we_d  = 1'b0;
            end
        endcase
    end

    // State, counter, captured command fields and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            lane_q      <= lane_t'(0);
            vreg_q      <= {REG_AW{1'b0}};
            stride_q    <= {ADDR_W{1'b0}};
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            rf_wr_en_q  <= 1'b0;
            rf_wr_dst_q <= {REG_AW{1'b0}};
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= {ADDR_W{1'b0}};
            mem_wdata_q <= {LANE_W{1'b0}};
        end else begin
            state_q     <= state_d;
            lane_q      <= lane_d;
            vreg_q      <= vreg_d;
            stride_q    <= stride_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            rf_wr_en_q  <= rf_wr_en_d;
            rf_wr_dst_q <= rf_wr_dst_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    // The read port is only claimed in the cycle a store is accepted.
    assign rf_rd_addr = (state_q == ST_IDLE && start && !op_load) ? vreg : {REG_AW{1'b0}};

    assign busy          = busy_q;
    assign done          = done_q;
    assign rf_wr_en      = rf_wr_en_q;
    assign rf_wr_dst     = rf_wr_dst_q;
    assign rf_wr_data    = rf_wr_en_q ? lbuf_vec_s : {VEC_W{1'b0}};
    assign mem.mem_req   = mem_req_q;
    assign mem.mem_we    = mem_we_q;
    assign mem.mem_addr  = mem_addr_q;
    assign mem.mem_wdata = mem_wdata_q;

endmodule
